// File: rtl/smg_scan_decoder.sv
// smg_scan_decoder
//   Reassembles a multiplexed 6-digit seven-segment scan stream into a
//   24-bit frame. Each scan word carries one 4-bit code together with an
//   active-low one-cold digit select. A digit is taken only after its scan
//   word has held steady for STABLE_CYC cycles. A frame is built in a
//   private shadow register and published all at once.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   rst          in   1   asynchronous reset, active high
//   scan_data    in  10   {code[3:0], sel[5:0]}, sel active low
//   frame_data   out 24   last complete frame, digit 0 in [23:20]
//   frame_valid  out  1   one-cycle pulse when frame_data updates
//   link_ok      out  1   high while frames arrive correctly
//   err_sel      out  1   pulse: accepted illegal select pattern
//   err_order    out  1   pulse: accepted out-of-sequence digit
//   err_timeout  out  1   pulse: no accepted digit for TIMEOUT cycles
//
// States
//   state    | meaning
//   ST_SYNC  | waiting for digit 0 to start a frame
//   ST_ACQ   | collecting digits exp_idx..5 in order
module smg_scan_decoder #(
  parameter int          STABLE_CYC = 16,
  parameter logic [15:0] TIMEOUT    = 16'd12000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  scan_data,
  output logic [23:0] frame_data,
  output logic        frame_valid,
  output logic        link_ok,
  output logic        err_sel,
  output logic        err_order,
  output logic        err_timeout
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_ACQ  = 1'b1;

  localparam int             SW       = $clog2(STABLE_CYC + 1);
  localparam logic [SW-1:0]  STAB_MAX = SW'(STABLE_CYC);
  localparam logic [SW-1:0]  STAB_ACC = SW'(STABLE_CYC - 1);
  localparam logic [15:0]    TO_LAST  = TIMEOUT - 16'd1;

  logic [9:0]    scan_q, scan_d;
  logic [9:0]    prev_q, prev_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [15:0]   dwell_q, dwell_d;
  logic [0:0]    state_q, state_d;
  logic [2:0]    exp_idx_q, exp_idx_d;
  // Only digits 0..4 are ever staged; digit 5 goes straight into the frame.
  logic [19:0]   shadow_q, shadow_d;
  logic [23:0]   frame_data_q, frame_data_d;
  logic          frame_valid_q, frame_valid_d;
  logic          link_ok_q, link_ok_d;
  logic          err_sel_q, err_sel_d;
  logic          err_order_q, err_order_d;
  logic          err_timeout_q, err_timeout_d;

  logic [3:0] code;
  logic [2:0] sel_idx;
  logic       sel_legal;
  logic       accept;
  logic       to_hit;

  // Replace the nibble for digit idx (0..4) in the shadow.
  function automatic logic [19:0] put_nib(input logic [19:0] sh,
                                          input logic [2:0]  idx,
                                          input logic [3:0]  nib);
    logic [4:0] sh_amt;
    sh_amt  = {idx, 2'b00};
    put_nib = (sh & ~(20'hF0000 >> sh_amt)) | ({nib, 16'h0000} >> sh_amt);
  endfunction

  always_comb begin
    sel_idx   = 3'd0;
    sel_legal = 1'b1;
    case (scan_q[5:0])
      6'b111110: sel_idx = 3'd0;
      6'b111101: sel_idx = 3'd1;
      6'b111011: sel_idx = 3'd2;
      6'b110111: sel_idx = 3'd3;
      6'b101111: sel_idx = 3'd4;
      6'b011111: sel_idx = 3'd5;
      default:   sel_legal = 1'b0;
    endcase
  end

  assign code = scan_q[9:6];
  // Counter saturates above STAB_ACC, so this fires once per dwell.
  assign accept = (stab_q == STAB_ACC);
  assign to_hit = (dwell_q == TO_LAST);

  always_comb begin
    scan_d        = scan_data;
    prev_d        = scan_q;
    stab_d        = stab_q;
    dwell_d       = dwell_q + 16'd1;
    state_d       = state_q;
    exp_idx_d     = exp_idx_q;
    shadow_d      = shadow_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    link_ok_d     = link_ok_q;
    err_sel_d     = 1'b0;
    err_order_d   = 1'b0;
    err_timeout_d = 1'b0;

    if (scan_q != prev_q) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end

    if (accept) begin
      // Acceptance outranks a coincident timeout.
      dwell_d = 16'd0;
      if (!sel_legal) begin
        err_sel_d = 1'b1;
        link_ok_d = 1'b0;
        state_d   = ST_SYNC;
        exp_idx_d = 3'd0;
      end else if (state_q == ST_SYNC) begin
        if (sel_idx == 3'd0) begin
          shadow_d  = put_nib(shadow_q, 3'd0, code);
          exp_idx_d = 3'd1;
          state_d   = ST_ACQ;
        end
      end else if (sel_idx == exp_idx_q) begin
        if (sel_idx == 3'd5) begin
          frame_data_d  = {shadow_q, code};
          frame_valid_d = 1'b1;
          link_ok_d     = 1'b1;
          state_d       = ST_SYNC;
          exp_idx_d     = 3'd0;
        end else begin
          shadow_d  = put_nib(shadow_q, sel_idx, code);
          exp_idx_d = exp_idx_q + 3'd1;
        end
      end else begin
        err_order_d = 1'b1;
        link_ok_d   = 1'b0;
        if (sel_idx == 3'd0) begin
          // A fresh digit 0 restarts the frame rather than waiting a full cycle.
          shadow_d  = put_nib(shadow_q, 3'd0, code);
          exp_idx_d = 3'd1;
        end else begin
          state_d   = ST_SYNC;
          exp_idx_d = 3'd0;
        end
      end
    end else if (to_hit) begin
      dwell_d       = 16'd0;
      err_timeout_d = 1'b1;
      link_ok_d     = 1'b0;
      state_d       = ST_SYNC;
      exp_idx_d     = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q        <= '0;
      prev_q        <= '0;
      stab_q        <= '0;
      dwell_q       <= '0;
      state_q       <= ST_SYNC;
      exp_idx_q     <= '0;
      shadow_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      link_ok_q     <= 1'b0;
      err_sel_q     <= 1'b0;
      err_order_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      scan_q        <= scan_d;
      prev_q        <= prev_d;
      stab_q        <= stab_d;
      dwell_q       <= dwell_d;
      state_q       <= state_d;
      exp_idx_q     <= exp_idx_d;
      shadow_q      <= shadow_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      link_ok_q     <= link_ok_d;
      err_sel_q     <= err_sel_d;
      err_order_q   <= err_order_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign link_ok     = link_ok_q;
  assign err_sel     = err_sel_q;
  assign err_order   = err_order_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_smg_scan_decoder.sv
// Directed bench for smg_scan_decoder with default parameters.
module tb_smg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  scan_data;
  logic [23:0] frame_data;
  logic        frame_valid, link_ok, err_sel, err_order, err_timeout;

  int vec_n = 0;
  int bad_n = 0;

  int fv_n = 0, es_n = 0, eo_n = 0, et_n = 0, oh_n = 0;
  int fv_b, es_b, eo_b, et_b;

  smg_scan_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .scan_data   (scan_data),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .link_ok     (link_ok),
    .err_sel     (err_sel),
    .err_order   (err_order),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) fv_n++;
      if (err_sel)     es_n++;
      if (err_order)   eo_n++;
      if (err_timeout) et_n++;
      if ((32'(frame_valid) + 32'(err_sel) + 32'(err_order) + 32'(err_timeout)) > 1) oh_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] code, input logic [5:0] sel, input int n);
    scan_data = {code, sel};
    repeat (n) @(negedge clk);
  endtask

  task automatic digit(input logic [3:0] code, input int idx, input int n);
    logic [5:0] s;
    s = ~(6'd1 << idx);
    drive(code, s, n);
  endtask

  task automatic frame(input logic [23:0] v, input int n);
    for (int i = 0; i < 6; i++) digit(v[23-4*i -: 4], i, n);
  endtask

  task automatic snap();
    fv_b = fv_n; es_b = es_n; eo_b = eo_n; et_b = et_n;
  endtask

  initial begin
    int k;
    int n;
    rst       = 1'b1;
    scan_data = {4'h0, 6'b011111};
    repeat (3) @(negedge clk);

    check("rst_frame_data", 32'(frame_data), 32'h0);
    check("rst_pulses", {28'h0, frame_valid, err_sel, err_order, err_timeout}, 32'h0);
    check("rst_link_ok", 32'(link_ok), 32'h0);

    rst = 1'b0;
    @(negedge clk);

    // Full frame, long dwells.
    snap();
    frame(24'h123456, 5000);
    check("f1_valid_cnt", 32'(fv_n - fv_b), 32'd1);
    check("f1_data", 32'(frame_data), 32'h123456);
    check("f1_link_ok", 32'(link_ok), 32'd1);
    check("f1_errors", 32'((es_n - es_b) + (eo_n - eo_b) + (et_n - et_b)), 32'd0);

    // Short select glitch early in the digit-0 dwell.
    snap();
    drive(4'h7, 6'b111110, 5);
    drive(4'h7, 6'b111101, 3);
    drive(4'h7, 6'b111110, 40);
    for (int i = 1; i < 6; i++) digit(4'(7 + i), i, 40);
    check("glitch_valid_cnt", 32'(fv_n - fv_b), 32'd1);
    check("glitch_data", 32'(frame_data), 32'h789ABC);
    check("glitch_errors", 32'((es_n - es_b) + (eo_n - eo_b) + (et_n - et_b)), 32'd0);
    check("glitch_link_ok", 32'(link_ok), 32'd1);

    // Illegal select held long enough to be accepted once.
    snap();
    drive(4'h3, 6'b111100, 20);
    drive(4'h3, 6'b011111, 30);
    check("illsel_cnt", 32'(es_n - es_b), 32'd1);
    check("illsel_link_ok", 32'(link_ok), 32'd0);
    check("illsel_data", 32'(frame_data), 32'h789ABC);

    // Good frame to restore link, then an out-of-order digit.
    frame(24'h13579B, 40);
    check("f3_data", 32'(frame_data), 32'h13579B);
    check("f3_link_ok", 32'(link_ok), 32'd1);
    snap();
    digit(4'h1, 0, 40);
    digit(4'h2, 1, 40);
    digit(4'h3, 3, 40);
    check("order_cnt", 32'(eo_n - eo_b), 32'd1);
    check("order_link_ok", 32'(link_ok), 32'd0);
    check("order_data", 32'(frame_data), 32'h13579B);
    check("order_no_frame", 32'(fv_n - fv_b), 32'd0);
    // Back in SYNC: digits 1..5 without digit 0 are silently ignored.
    snap();
    for (int i = 1; i < 6; i++) digit(4'hE, i, 40);
    check("sync_ignore_frame", 32'(fv_n - fv_b), 32'd0);
    check("sync_ignore_err", 32'((es_n - es_b) + (eo_n - eo_b) + (et_n - et_b)), 32'd0);

    // Frame then frozen input until timeout.
    for (int i = 0; i < 5; i++) digit(4'(2 * i + 2), i, 40);
    snap();
    scan_data = {4'hC, 6'b011111};
    k = 0;
    while (!frame_valid && k < 100) begin @(negedge clk); k++; end
    check("to_frame_seen", 32'(frame_valid), 32'd1);
    check("to_frame_data", 32'(frame_data), 32'h2468AC);
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 13000);
    check("to_latency", 32'(n), 32'd12000);
    check("to_link_ok", 32'(link_ok), 32'd0);
    check("to_data_kept", 32'(frame_data), 32'h2468AC);
    repeat (2) @(negedge clk);
    check("to_single_pulse", 32'(et_n - et_b), 32'd1);

    // Reset mid-frame, then a full new frame.
    digit(4'h1, 0, 40);
    digit(4'h1, 1, 40);
    digit(4'h1, 2, 40);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_data", 32'(frame_data), 32'h0);
    check("mid_rst_link", 32'(link_ok), 32'd0);
    rst = 1'b0;
    snap();
    for (int i = 0; i < 5; i++) digit(4'(10 + i), i, 40);
    check("post_rst_no_early", 32'(fv_n - fv_b), 32'd0);
    check("post_rst_data_hold", 32'(frame_data), 32'h0);
    digit(4'hF, 5, 40);
    check("post_rst_valid_cnt", 32'(fv_n - fv_b), 32'd1);
    check("post_rst_data", 32'(frame_data), 32'hABCDEF);
    check("post_rst_link", 32'(link_ok), 32'd1);

    check("pulses_one_hot", 32'(oh_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, bad_n);
    $finish;
  end

endmodule

// File: doc/smg_scan_decoder.md
SMG_SCAN_DECODER -- requirements
Module: smg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 16: cycles a scan word must stay unchanged before a digit is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 16'd12000: maximum cycles between accepted digits before the link is declared lost.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port scan_data, input, 10: scan word {code[3:0], sel[5:0]}; sel is active-low, one zero per digit.
REQ-006 SHALL have port frame_data, output, 24: last complete reassembled 6-digit value, digit 0 in [23:20] through digit 5 in [3:0].
REQ-007 SHALL have port frame_valid, output, 1: one-cycle pulse when frame_data is updated.
REQ-008 SHALL have port link_ok, output, 1: high while frames are arriving correctly.
REQ-009 SHALL have port err_sel, output, 1: one-cycle pulse on an accepted illegal select pattern.
REQ-010 SHALL have port err_order, output, 1: one-cycle pulse on an out-of-sequence digit.
REQ-011 SHALL have port err_timeout, output, 1: one-cycle pulse on link timeout.

Function
REQ-012 SHALL register scan_data once (scan_q) before any decoding; all latencies count from scan_q.
REQ-013 SHALL decode sel: 111110->idx0, 111101->idx1, 111011->idx2, 110111->idx3, 101111->idx4, 011111->idx5; any other pattern is illegal.
REQ-014 SHALL keep a stability counter: reset to 0 when scan_q differs from its previous value, otherwise increment, saturating at STABLE_CYC.
REQ-015 SHALL accept a digit exactly once per dwell, on the cycle the stability counter reaches STABLE_CYC-1.
REQ-016 SHALL implement states SYNC (waiting for idx0) and ACQ (collecting idx1..5), with expected-index counter exp_idx (0..5).
REQ-017 In SYNC, an accepted idx0 SHALL store code into shadow[23:20], set exp_idx=1 and enter ACQ; other legal indices SHALL be ignored without error.
REQ-018 In ACQ, an accepted idx equal to exp_idx SHALL store code into its nibble and increment exp_idx.
REQ-019 On acceptance of idx5 in order, the block SHALL load frame_data with the shadow plus the new nibble on the next cycle, pulse frame_valid, set link_ok=1, and return to SYNC with exp_idx=0.
REQ-020 In ACQ, an accepted idx not equal to exp_idx SHALL pulse err_order and clear link_ok; if that idx is 0 the block SHALL restart the frame (store nibble, exp_idx=1, remain in ACQ), otherwise it SHALL go to SYNC.
REQ-021 An accepted illegal sel SHALL pulse err_sel, clear link_ok, go to SYNC, and leave frame_data unchanged.
REQ-022 A dwell counter SHALL clear on every accepted digit and otherwise increment; on reaching TIMEOUT-1 it SHALL pulse err_timeout, clear link_ok, go to SYNC, and clear itself.
REQ-023 frame_data SHALL change only on frame_valid; partial frames SHALL never be visible.
REQ-024 If a timeout and a digit acceptance occur on the same cycle, acceptance SHALL win and no err_timeout SHALL be issued.
REQ-025 Only one of frame_valid, err_sel, err_order, err_timeout SHALL be high in any cycle.

Reset
REQ-026 While rst is high, frame_data=0, frame_valid=0, link_ok=0, all error pulses=0, state=SYNC, exp_idx=0, and all counters=0.
REQ-027 Reset asserted mid-frame SHALL discard the shadow; the first frame after release SHALL begin at idx0.

Verification
REQ-028 Six digits 0x1,0x2,0x3,0x4,0x5,0x6 with sel 111110..011111, 5000 cycles each -> frame_valid once, frame_data=24'h123456, link_ok=1.
REQ-029 A 3-cycle glitch of sel=111101 inside the idx0 dwell (STABLE_CYC=16) -> glitch ignored, no error, frame completes normally.
REQ-030 Sequence idx0, idx1, idx3 -> err_order pulse at idx3 acceptance, link_ok=0, state SYNC, frame_data unchanged.
REQ-031 sel=111100 held 20 cycles -> single err_sel pulse, link_ok=0.
REQ-032 scan_data frozen after a valid frame -> err_timeout pulse 12000 cycles after the last acceptance, link_ok=0, frame_data retained.
REQ-033 rst pulsed after idx2 of a frame, then a full frame 0xABCDEF -> frame_data=24'hABCDEF, with no frame_valid before idx5 of the new frame.
